dmem_bus_bridge: RTL and testbench

Data-memory bridge between the core's load/store port and a valid/ready memory bus with variable wait states. Captures one core access, drives it onto the bus, and holds the core with `data_stall` until the response arrives. Returns read data and converts bus errors and timeouts into `data_err`. Sits directly downstream of the core's MEM stage; one outstanding transaction at a time.

---
 rtl/dmem_bus_if.sv | 23 ++
 rtl/dmem_bus_bridge.sv | 115 +++++++++++
 tb/tb_dmem_bus_bridge.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_if.sv
// Valid/ready data-memory bus between the load/store bridge (master) and memory (slave).
// Requests hold until bus_ready; responses arrive later on bus_rvalid.
interface dmem_bus_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_rerr;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rvalid, bus_rdata, bus_rerr
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rvalid, bus_rdata, bus_rerr
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Single-outstanding bridge from the core's load/store port to a valid/ready memory bus.
// Stalls the core until the bus responds, and folds bus errors and timeouts into o_data_err.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_mem,
  input  logic        i_wmem,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wmask,
  output logic [31:0] o_data_i,
  output logic        o_data_stall,
  output logic        o_data_err,
  dmem_bus_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic w_idle;
  logic w_in_req;
  logic w_in_resp;
  logic w_in_done;
  logic w_empty_store;
  logic w_timeout;

  assign w_idle        = (r_state == S_IDLE);
  assign w_in_req      = (r_state == S_REQ);
  assign w_in_resp     = (r_state == S_RESP);
  assign w_in_done     = (r_state == S_DONE);
  assign w_empty_store = i_wmem && (i_wmask == 4'b0000);
  assign w_timeout     = (r_cnt == L_TIMEOUT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_mem) begin
            // Load fields are zeroed at capture so the bus never sees stale store data.
            r_we    <= i_wmem;
            r_addr  <= i_addr & 32'hFFFF_FFFC;
            r_wdata <= i_wmem ? i_wdata : 32'h0;
            r_wstrb <= i_wmem ? i_wmask : 4'b0000;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_state <= w_empty_store ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (bus.bus_ready) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_cnt <= r_cnt + 1'b1;
          // A response in the last allowed cycle still wins over the timeout.
          if (bus.bus_rvalid) begin
            r_rdata <= (!r_we && !bus.bus_rerr) ? bus.bus_rdata : 32'h0;
            r_err   <= bus.bus_rerr;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_valid = w_in_req;
  assign bus.bus_we    = w_in_req & r_we;
  assign bus.bus_addr  = w_in_req ? r_addr  : 32'h0;
  assign bus.bus_wdata = w_in_req ? r_wdata : 32'h0;
  assign bus.bus_wstrb = w_in_req ? r_wstrb : 4'b0000;

  assign o_data_i     = w_in_done ? r_rdata : 32'h0;
  assign o_data_err   = w_in_done & r_err;
  assign o_data_stall = (w_idle & i_req_mem & reset) | w_in_req | w_in_resp;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Randomized scoreboard bench for dmem_bus_bridge: a driver queues expected results,
// a bus responder follows per-transaction wait plans, and a monitor checks each completion.
`timescale 1ns/1ps
module tb_dmem_bus_bridge;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_mem = 1'b0;
  logic        wmem = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] data_i;
  logic        data_stall;
  logic        data_err;

  dmem_bus_if bus ();

  dmem_bus_bridge #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_mem    (req_mem),
    .i_wmem       (wmem),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .i_wmask      (wmask),
    .o_data_i     (data_i),
    .o_data_stall (data_stall),
    .o_data_err   (data_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rw;     // cycles with bus_ready low before it is raised
    int          vw;     // cycles between the ready cycle+1 and rvalid
    logic [31:0] rdata;
    logic        rerr;
  } plan_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          stall;
    int          vcyc;
    logic [31:0] baddr;
    logic        bwe;
    logic [31:0] bwdata;
    logic [3:0]  bwstrb;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    done_cnt = 0;
  bit    resp_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: outcome of one access from the bus wait plan.
  function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] m, input plan_t p);
    exp_t e;
    e.baddr  = {a[31:2], 2'b00};
    e.bwe    = w;
    e.bwdata = w ? d : 32'h0;
    e.bwstrb = w ? m : 4'h0;
    if (w && m == 4'h0) begin
      e.data = 0; e.err = 0; e.stall = 1; e.vcyc = 0;
    end else if (p.rw + 1 + p.vw > TO) begin
      e.data = 0; e.err = 1; e.stall = TO + 2;
      e.vcyc = ((p.rw < TO) ? p.rw : TO) + 1;
    end else begin
      e.err   = p.rerr;
      e.data  = (!w && !p.rerr) ? p.rdata : 32'h0;
      e.stall = p.rw + p.vw + 3;
      e.vcyc  = p.rw + 1;
    end
    return e;
  endfunction

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input plan_t p);
    @(posedge clk); #1;
    req_mem = 1'b1; wmem = w; addr = a; wdata = d; wmask = m;
    exp_q.push_back(model(w, a, d, m, p));
    if (!(w && m == 4'h0)) plan_q.push_back(p);
    @(posedge clk); #1;
    req_mem = 1'b0; wmem = 1'($urandom); addr = $urandom; wdata = $urandom; wmask = 4'($urandom);
  endtask

  task automatic wait_idle(input int start, input bit need_done);
    int k = 0;
    while (((need_done && done_cnt == start) || resp_busy) && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (k >= 200) begin
      n_chk++;
      $display("FAIL wait_bound: done_cnt=%0d resp_busy=%0d, required completion within 200 cycles", done_cnt, resp_busy);
    end
  endtask

  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input plan_t p);
    int start = done_cnt;
    issue(w, a, d, m, p);
    wait_idle(start, 1'b1);
  endtask

  // Bus responder: follows the plan of each request it sees.
  initial begin
    plan_t p;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0; bus.bus_rerr = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.bus_rdata = $urandom;
      bus.bus_rerr  = 1'($urandom);
      if (bus.bus_valid && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        resp_busy = 1'b1;
        for (int j = 0; j <= p.rw; j++) begin
          bus.bus_ready = (j == p.rw);
          @(posedge clk); #1;
        end
        bus.bus_ready = 1'b0;
        for (int j = 0; j < p.vw; j++) begin
          bus.bus_rdata = $urandom;
          @(posedge clk); #1;
        end
        bus.bus_rvalid = 1'b1; bus.bus_rdata = p.rdata; bus.bus_rerr = p.rerr;
        @(posedge clk); #1;
        bus.bus_rvalid = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: a falling data_stall marks the DONE cycle; outside transactions all outputs are 0.
  initial begin
    int          run, vc, txn;
    bit          prev, stable, seen;
    logic [31:0] fa, fd;
    logic        fw;
    logic [3:0]  fs;
    exp_t        e;
    run = 0; vc = 0; txn = 0; prev = 0; stable = 1; seen = 0;
    fa = '0; fd = '0; fw = 0; fs = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run = 0; vc = 0; prev = 0; stable = 1; seen = 0;
      end else begin
        if (data_stall) begin
          run++;
          if (bus.bus_valid) begin
            vc++;
            if (!seen) begin
              fa = bus.bus_addr; fd = bus.bus_wdata; fw = bus.bus_we; fs = bus.bus_wstrb; seen = 1;
            end else if (fa !== bus.bus_addr || fd !== bus.bus_wdata || fw !== bus.bus_we || fs !== bus.bus_wstrb) begin
              stable = 0;
            end
          end
        end else if (prev) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: data_i=0x%08h err=%0d, required no completion", data_i, data_err);
          end else begin
            e = exp_q.pop_front();
            chk("data_i", data_i, e.data);
            chk("data_err", 32'(data_err), 32'(e.err));
            chk("stall_len", run, e.stall);
            chk("valid_cycles", vc, e.vcyc);
            chk("done_bus_valid", 32'(bus.bus_valid), 0);
            if (e.vcyc > 0) begin
              chk("bus_addr", fa, e.baddr);
              chk("bus_we", 32'(fw), 32'(e.bwe));
              chk("bus_wdata", fd, e.bwdata);
              chk("bus_wstrb", 32'(fs), 32'(e.bwstrb));
              chk("fields_stable", 32'(stable), 1);
            end
            $display("txn %0d: data_i=0x%08h err=%0d stall=%0d valid_cycles=%0d", txn, data_i, data_err, run, vc);
          end
          txn++;
          done_cnt++;
          run = 0; vc = 0; seen = 0; stable = 1;
        end else begin
          chk("idle_data_i", data_i, 0);
          chk("idle_ctrl", {28'h0, data_err, bus.bus_valid, bus.bus_we, 1'b0}, 0);
          chk("idle_bus_fields", bus.bus_addr | bus.bus_wdata | {28'h0, bus.bus_wstrb}, 0);
        end
        prev = data_stall;
      end
    end
  end

  initial begin
    plan_t p;
    int    start;
    logic  w;
    logic [3:0] m;

    // Reset with a pending request: the combinational stall term must stay low.
    reset = 1'b0; req_mem = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(data_stall), 0);
    chk("rst_bus_valid", 32'(bus.bus_valid), 0);
    chk("rst_data_i", data_i, 0);
    chk("rst_data_err", 32'(data_err), 0);
    req_mem = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    p = '{rw: 0, vw: 0, rdata: 32'hDEADBEEF, rerr: 1'b0};
    run_txn(1'b0, 32'h0000_1006, 32'h0, 4'h0, p);
    p = '{rw: 3, vw: 1, rdata: 32'hA5A5_A5A5, rerr: 1'b0};
    run_txn(1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, p);
    p = '{rw: 1, vw: 0, rdata: 32'hCAFE_F00D, rerr: 1'b1};
    run_txn(1'b0, 32'h0000_3008, 32'h0, 4'h0, p);
    // Ready never arrives in time; the late ready/rvalid land after DONE.
    p = '{rw: TO + 2, vw: 0, rdata: 32'h1111_2222, rerr: 1'b0};
    run_txn(1'b0, 32'h0000_400C, 32'h0, 4'h0, p);
    p = '{rw: 0, vw: 0, rdata: 32'h0, rerr: 1'b0};
    run_txn(1'b1, 32'h0000_5000, 32'hFFFF_FFFF, 4'b0000, p);

    // Reset while waiting for the response; the following rvalid must be ignored.
    start = done_cnt;
    p = '{rw: 0, vw: 6, rdata: 32'h7777_8888, rerr: 1'b0};
    plan_q.push_back(p);
    @(posedge clk); #1;
    req_mem = 1'b1; wmem = 1'b0; addr = 32'h0000_6004;
    @(posedge clk); #1;
    req_mem = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall", 32'(data_stall), 0);
    chk("rst_mid_bus_valid", 32'(bus.bus_valid), 0);
    wait_idle(start, 1'b0);
    repeat (2) @(posedge clk);
    chk("rst_mid_no_done", done_cnt, start);

    p = '{rw: 1, vw: 2, rdata: 32'h0BAD_CAFE, rerr: 1'b0};
    run_txn(1'b0, 32'h0000_7002, 32'h0, 4'h0, p);

    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom_range(0, 1));
      m = 4'($urandom_range(0, 15));
      if (m == 4'h0 && $urandom_range(0, 2) != 0) m = 4'hF;
      p.rw    = ($urandom_range(0, 6) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 3);
      p.vw    = ($urandom_range(0, 6) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 3);
      p.rdata = $urandom;
      p.rerr  = ($urandom_range(0, 4) == 0);
      run_txn(w, $urandom, $urandom, m, p);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
